// File: rtl/ready_operand_issue_queue_pkg.sv
// rtl/ready_operand_issue_queue_pkg.sv - shared sizes and entry record for the ready-operand issue queue
package ready_operand_issue_queue_pkg;

  localparam int TAG_W     = 6;
  localparam int NUM_PREGS = 64;
  localparam int DEPTH     = 8;
  localparam int NUM_WAKE  = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] src0;
    logic [TAG_W-1:0] src1;
    logic [TAG_W-1:0] dest;
    logic             rdy0;
    logic             rdy1;
  } entry_t;

endpackage

// File: rtl/oldest_ready_select.sv
// rtl/oldest_ready_select.sv - lowest-index (oldest) priority pick over a request vector
module oldest_ready_select #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        grant_o[i] = 1'b1;
        index_o    = IDX_W'(i);
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ready_operand_issue_queue.sv
// rtl/ready_operand_issue_queue.sv - collapsing age-ordered issue queue with operand wakeup
module ready_operand_issue_queue
  import ready_operand_issue_queue_pkg::*;
#(
  parameter int DEPTH    = ready_operand_issue_queue_pkg::DEPTH,
  parameter int NUM_WAKE = ready_operand_issue_queue_pkg::NUM_WAKE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NUM_PREGS-1:0] readyVector,
  input  logic [NUM_WAKE-1:0]  wakeEn,
  input  logic [TAG_W-1:0]     wakeTag0,
  input  logic [TAG_W-1:0]     wakeTag1,
  input  logic [TAG_W-1:0]     wakeTag2,
  input  logic [TAG_W-1:0]     wakeTag3,
  input  logic                 flush,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [TAG_W-1:0]     inSrc0,
  input  logic [TAG_W-1:0]     inSrc1,
  input  logic [TAG_W-1:0]     inDest,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [TAG_W-1:0]     outSrc0,
  output logic [TAG_W-1:0]     outSrc1,
  output logic [TAG_W-1:0]     outDest,
  output logic [3:0]           occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woke  [DEPTH];
  entry_t           new_ent;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] ins_pos;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic             any_ready;
  logic             do_issue, do_ins;
  logic [TAG_W-1:0] wtag [4];

  assign wtag[0] = wakeTag0;
  assign wtag[1] = wakeTag1;
  assign wtag[2] = wakeTag2;
  assign wtag[3] = wakeTag3;

  function automatic logic wake_hit(input logic [TAG_W-1:0] tag);
    wake_hit = 1'b0;
    for (int j = 0; j < NUM_WAKE; j++) begin
      if (wakeEn[j] && wtag[j] == tag) wake_hit = 1'b1;
    end
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = ent_q[i].valid && ent_q[i].rdy0 && ent_q[i].rdy1;
    end
  end

  oldest_ready_select #(.N(DEPTH), .IDX_W(IDX_W)) u_select (
    .req_i   (req),
    .grant_o (grant),
    .index_o (sel_idx),
    .any_o   (any_ready)
  );

  // Reset is folded in so the handshakes read 0 for the whole time reset is high.
  assign inReady  = !reset && en && !flush && (occ_q < OCC_W'(DEPTH));
  assign outValid = !reset && en && !flush && any_ready;
  assign do_issue = outValid && outReady;
  assign do_ins   = inValid && inReady;
  assign ins_pos  = do_issue ? occ_q - OCC_W'(1) : occ_q;

  assign outSrc0   = outValid ? ent_q[sel_idx].src0 : '0;
  assign outSrc1   = outValid ? ent_q[sel_idx].src1 : '0;
  assign outDest   = outValid ? ent_q[sel_idx].dest : '0;
  assign occupancy = 4'(occ_q);

  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.src0  = inSrc0;
    new_ent.src1  = inSrc1;
    new_ent.dest  = inDest;
    new_ent.rdy0  = (inSrc0 == '0) || readyVector[inSrc0] || wake_hit(inSrc0);
    new_ent.rdy1  = (inSrc1 == '0) || readyVector[inSrc1] || wake_hit(inSrc1);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (ent_q[i].valid) begin
        woke[i].rdy0 = ent_q[i].rdy0 || (ent_q[i].src0 != '0 && wake_hit(ent_q[i].src0));
        woke[i].rdy1 = ent_q[i].rdy1 || (ent_q[i].src1 != '0 && wake_hit(ent_q[i].src1));
      end
    end
  end

  // Wakeups are applied first, then the issued slot collapses, then the insert lands at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    occ_d = occ_q;
    if (en) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
        occ_d = '0;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          ent_d[i] = (do_issue && i >= int'(sel_idx)) ? woke[i+1] : woke[i];
        end
        ent_d[DEPTH-1] = do_issue ? '0 : woke[DEPTH-1];
        if (do_ins) ent_d[ins_pos[IDX_W-1:0]] = new_ent;
        occ_d = occ_q + OCC_W'(do_ins) - OCC_W'(do_issue);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      occ_q <= occ_d;
    end
  end

endmodule
